// File: rtl/phasediff_avg.sv
// phasediff_avg: wrapped phase difference of two 9Q10 hydrophone angles,
// averaged over windows of 2**LOG2N samples.
// The sample register, the subtract and the wrap each take one pipeline stage.
// The window accumulator consumes the wrapped sample in the fourth cycle.
module phasediff_avg #(
  parameter int LOG2N = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [18:0]       angle_a,
  input  logic signed [18:0]       angle_b,
  input  logic                     clear,
  output logic signed [18:0]       avg_out,
  output logic                     avg_valid,
  output logic        [LOG2N:0]    fill
);

  localparam int DATA_W = 19;
  localparam int ACC_W  = LOG2N + DATA_W;
  localparam logic signed [DATA_W:0] HALF_TURN = 20'sd184320;
  localparam logic signed [DATA_W:0] FULL_TURN = 20'sd368640;
  localparam logic [LOG2N:0]         LAST      = {1'b0, {LOG2N{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Fold a 20-bit difference into [-180, +180) degrees.
  function automatic logic signed [DATA_W-1:0] wrap_angle(input logic signed [DATA_W:0] d);
    logic signed [DATA_W:0] r;
    if (d >= HALF_TURN)
      r = d - FULL_TURN;
    else if (d < -HALF_TURN)
      r = d + FULL_TURN;
    else
      r = d;
    return DATA_W'(r);
  endfunction

  // Divide the window sum by N, rounding toward minus infinity.
  function automatic logic signed [DATA_W-1:0] floor_avg(input logic signed [ACC_W-1:0] sum);
    return DATA_W'(sum >>> LOG2N);
  endfunction

  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic                     vld_p0;
  logic signed [DATA_W:0]   d_p1;
  logic                     vld_p1;
  logic signed [DATA_W-1:0] w_p2;
  logic                     vld_p2;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt, acc_sum;
  logic        [LOG2N:0]    fill_nxt;
  logic                     done_now;

  // Valid pipeline; clear drops every sample still in flight.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Data pipeline: p0 sample, p1 sign-extended difference, p2 wrapped difference.
  always_ff @(posedge clock) begin
    a_p0 <= angle_a;
    b_p0 <= angle_b;
    // p0 -> p1: subtract in 20 bits so the full +/-360 range is representable
    d_p1 <= (DATA_W+1)'(a_p0) - (DATA_W+1)'(b_p0);
    // p1 -> p2: wrap back into one turn
    w_p2 <= wrap_angle(d_p1);
  end

  // Window FSM state register.
  always_ff @(posedge clock) begin
    if (!reset || clear)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Window FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vld_p2) state_nxt = ACCUM;
      ACCUM:   if (vld_p2 && fill == LAST) state_nxt = DONE;
      DONE:    state_nxt = vld_p2 ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window FSM outputs: next accumulator, next fill and window completion.
  always_comb begin
    acc_nxt  = acc;
    fill_nxt = fill;
    done_now = 1'b0;
    acc_sum  = acc + ACC_W'(w_p2);
    case (state)
      ACCUM: begin
        if (vld_p2) begin
          if (fill == LAST) begin
            acc_nxt  = '0;
            fill_nxt = '0;
            done_now = 1'b1;
          end else begin
            acc_nxt  = acc_sum;
            fill_nxt = fill + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both open a fresh window on an arriving sample
        if (vld_p2) begin
          acc_nxt  = ACC_W'(w_p2);
          fill_nxt = (LOG2N+1)'(1);
        end
      end
    endcase
  end

  // Accumulator, fill counter and averaged result registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc       <= '0;
      fill      <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      fill      <= '0;
      avg_valid <= 1'b0;
    end else begin
      // p2 -> result: the window closes on its Nth sample
      acc       <= acc_nxt;
      fill      <= fill_nxt;
      avg_valid <= done_now;
      if (done_now)
        avg_out <= floor_avg(acc_sum);
    end
  end

endmodule

// File: tb/tb_phasediff_avg.sv
// Directed bench for phasediff_avg (LOG2N = 4): a reference model queues the
// expected average and its arrival cycle for every completed window.
module tb_phasediff_avg;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [18:0] angle_a;
  logic signed [18:0] angle_b;
  logic               clear;
  logic signed [18:0] avg_out;
  logic               avg_valid;
  logic        [4:0]  fill;

  phasediff_avg #(.LOG2N(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .angle_a   (angle_a),
    .angle_b   (angle_b),
    .clear     (clear),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .fill      (fill)
  );

  always #5 clock = ~clock;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   m_acc = 0;
  int   m_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Result monitor: every avg_valid pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset && avg_valid) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $error("FAIL unexpected_valid: observed avg_out %0d at cycle %0d, required no pulse", int'(avg_out), cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        assert (int'(avg_out) === e.val && cyc == e.cyc)
        else begin
          nerr++;
          $error("FAIL avg_out: observed %0d at cycle %0d, required %0d at cycle %0d", int'(avg_out), cyc, e.val, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t e;
      e = sb.pop_front();
      nvec++;
      nerr++;
      $error("FAIL missing_valid: observed no pulse by cycle %0d, required %0d at cycle %0d", cyc, e.val, e.cyc);
    end
  end

  task automatic check(input string tag, input int obs, input int expv);
    nvec++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, expv);
    end
  endtask

  // One clock of stimulus, with the reference model updated in step.
  task automatic step(input logic v, input int a, input int b, input logic clr, input logic rst);
    int d;
    @(negedge clock);
    in_valid = v;
    angle_a  = 19'(a);
    angle_b  = 19'(b);
    clear    = clr;
    reset    = rst;
    if (!rst || clr) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (v) begin
      d = a - b;
      if (d >= 184320) d -= 368640;
      else if (d < -184320) d += 368640;
      m_acc += d;
      m_cnt++;
      if (m_cnt == 16) begin
        sb.push_back('{val: m_acc >>> 4, cyc: cyc + 4});
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic sample(input int a, input int b);
    step(1'b1, a, b, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic window(input int a, input int b);
    for (int i = 0; i < 16; i++) sample(a, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    angle_a  = '0;
    angle_b  = '0;
    repeat (3) @(negedge clock);
    check("reset_avg_out", int'(avg_out), 0);
    check("reset_avg_valid", int'(avg_valid), 0);
    check("reset_fill", int'(fill), 0);

    // Constant 30 degree difference
    idle(2);
    window(10240, -20480);
    idle(5);
    check("const_fill", int'(fill), 0);

    // Wrap on both sides of the seam
    window(174080, -174080);
    idle(2);
    window(-174080, 174080);
    idle(2);

    // Exactly +180 folds to -180; just below stays positive
    window(92160, -92160);
    idle(2);
    window(92160, -92159);
    idle(2);

    // Floor rounding of tiny sums
    for (int i = 0; i < 15; i++) sample(0, 0);
    sample(0, 1);
    idle(2);
    for (int i = 0; i < 15; i++) sample(0, 0);
    sample(1, 0);
    idle(5);

    // 48 back-to-back samples, diff ramps 1024 per window
    for (int i = 0; i < 48; i++) sample(i * 64, -5000);
    idle(5);

    // Window with random gaps
    for (int i = 0; i < 16; i++) begin
      sample(5000 + i * 7, -(i % 3));
      idle($urandom_range(0, 3));
    end
    idle(5);

    // Clear mid-window, colliding with an in_valid, samples still in flight
    for (int i = 0; i < 7; i++) sample(20000, 0);
    step(1'b1, 50000, 0, 1'b1, 1'b1);
    idle(4);
    check("clear_fill", int'(fill), 0);
    window(5120, 0);
    idle(5);

    // Reset mid-window
    for (int i = 0; i < 7; i++) sample(30000, 1000);
    idle(4);
    check("pre_reset_fill", int'(fill), 7);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clock);
    check("mid_reset_avg_out", int'(avg_out), 0);
    check("mid_reset_avg_valid", int'(avg_valid), 0);
    check("mid_reset_fill", int'(fill), 0);
    reset = 1'b1;
    window(-30000, -10000);
    idle(10);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
